// File: rtl/ps2_move_pkg.sv
// Shared scan codes, parser states and width helpers for the PS/2 move front end.
// Imported by ps2_move_ctrl and move_fifo.
package ps2_move_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        P_IDLE,
        P_E0,
        P_F0,
        P_E0F0
    } parse_t;

    function automatic int cw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Top-row digit keys 1..9; 0 means not a digit.
    function automatic logic [3:0] digit_of(input logic [7:0] c);
        case (c)
            8'h16:   return 4'd1;
            8'h1E:   return 4'd2;
            8'h26:   return 4'd3;
            8'h25:   return 4'd4;
            8'h2E:   return 4'd5;
            8'h36:   return 4'd6;
            8'h3D:   return 4'd7;
            8'h3E:   return 4'd8;
            8'h46:   return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/move_fifo.sv
// First-word fall-through sync FIFO holding queued column moves.
// Push while full is only accepted when a pop happens in the same cycle.
module move_fifo
    import ps2_move_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_move_ctrl.sv
// PS/2 + pushbutton front end queueing column drops for the Connect-N core.
// Define TYPEMATIC_FILTER_EN to ignore auto-repeat makes of a held key.
module ps2_move_ctrl
    import ps2_move_pkg::*;
#(
    parameter int NUM_COLS   = 7,
    parameter int FIFO_DEPTH = 4,
    localparam int CW   = cw_of(NUM_COLS),
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic [7:0]      rx_data,
    input  logic            rx_en,
    input  logic            btn_drop_n,
    input  logic            move_ready,
    input  logic            ovf_clr,
    output logic            move_valid,
    output logic [CW-1:0]   move_col,
    output logic [CW-1:0]   cursor_col,
    output logic [CNTW-1:0] fifo_count,
    output logic            overflow,
    output logic [7:0]      last_code
);

`ifdef TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    parse_t          st, st_n;
    logic            mk, brk, ext, act;
    logic            held_v, match;
    logic [8:0]      held_k;
    logic [3:0]      dig;
    logic [CW-1:0]   cur_n, col_n, push_col_q;
    logic            push_n, push_q;
    logic [2:0]      btn_s;
    logic            btn_fall, pend_btn;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty, lost;
    logic [CW-1:0]   fifo_din;

    always_comb begin
        st_n = st;
        mk   = 1'b0;
        brk  = 1'b0;
        ext  = 1'b0;
        if (rx_en) begin
            unique case (st)
                P_IDLE: begin
                    if (rx_data == SC_E0)      st_n = P_E0;
                    else if (rx_data == SC_F0) st_n = P_F0;
                    else                       mk = 1'b1;
                end
                P_E0: begin
                    ext = 1'b1;
                    if (rx_data == SC_F0) begin
                        st_n = P_E0F0;
                    end else begin
                        mk   = 1'b1;
                        st_n = P_IDLE;
                    end
                end
                P_F0: begin
                    brk  = 1'b1;
                    st_n = P_IDLE;
                end
                P_E0F0: begin
                    brk  = 1'b1;
                    ext  = 1'b1;
                    st_n = P_IDLE;
                end
                default: st_n = P_IDLE;
            endcase
        end
    end

    assign match = held_v & (held_k == {ext, rx_data});
    assign act   = mk & ~(FILTER & match);

    always_comb begin
        cur_n  = cursor_col;
        col_n  = cursor_col;
        push_n = 1'b0;
        dig    = digit_of(rx_data);
        if (act && !ext) begin
            if (dig != 4'd0 && int'(dig) <= NUM_COLS) begin
                cur_n  = CW'(dig - 4'd1);
                col_n  = CW'(dig - 4'd1);
                push_n = 1'b1;
            end else if (rx_data == SC_ENTER || rx_data == SC_SPACE) begin
                push_n = 1'b1;
            end
        end else if (act && ext) begin
            if (rx_data == SC_LEFT)
                cur_n = (cursor_col == '0) ? LAST_COL : cursor_col - 1'b1;
            else if (rx_data == SC_RIGHT)
                cur_n = (cursor_col == LAST_COL) ? '0 : cursor_col + 1'b1;
        end
    end

    // PS/2 pushes take the FIFO slot; a pending button waits a cycle.
    assign btn_fall  = btn_s[2] & ~btn_s[1];
    assign fifo_push = push_q | pend_btn;
    assign fifo_din  = push_q ? push_col_q : cursor_col;
    assign fifo_pop  = move_valid & move_ready;
    assign lost      = fifo_push & fifo_full & ~fifo_pop;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            st         <= P_IDLE;
            cursor_col <= '0;
            last_code  <= '0;
            push_q     <= 1'b0;
            push_col_q <= '0;
            btn_s      <= 3'b111;
            pend_btn   <= 1'b0;
            overflow   <= 1'b0;
            held_v     <= 1'b0;
            held_k     <= '0;
        end else begin
            st         <= st_n;
            cursor_col <= cur_n;
            push_q     <= push_n;
            push_col_q <= col_n;
            btn_s      <= {btn_s[1:0], btn_drop_n};
            pend_btn   <= btn_fall | (pend_btn & push_q);
            overflow   <= (overflow & ~ovf_clr) | lost;
            if (act) begin
                last_code <= rx_data;
                held_v    <= 1'b1;
                held_k    <= {ext, rx_data};
            end else if (brk && match) begin
                held_v <= 1'b0;
            end
        end
    end

    move_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (move_col),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign move_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_move_ctrl.sv
// Bench for ps2_move_ctrl: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_ps2_move_ctrl;

    localparam int NC  = 7;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       btn_drop_n;
    logic       move_ready;
    logic       ovf_clr;
    logic       move_valid;
    logic [2:0] move_col;
    logic [2:0] cursor_col;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] last_code;

    int total = 0;
    int pass  = 0;

    ps2_move_ctrl #(
        .NUM_COLS   (NC),
        .FIFO_DEPTH (DEP)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .btn_drop_n (btn_drop_n),
        .move_ready (move_ready),
        .ovf_clr    (ovf_clr),
        .move_valid (move_valid),
        .move_col   (move_col),
        .cursor_col (cursor_col),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .last_code  (last_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int mq[$];
    int mcur, mlast, mst, sched_c, hk;
    bit sched_v, pend, h1, h2, h3, movf, hv;

    function automatic int digit(input int b);
        case (b)
            'h16: return 1; 'h1E: return 2; 'h26: return 3;
            'h25: return 4; 'h2E: return 5; 'h36: return 6;
            'h3D: return 7; 'h3E: return 8; 'h46: return 9;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        mcur = 0; mlast = 0; mst = 0;
        sched_v = 0; sched_c = 0; pend = 0;
        h1 = 1; h2 = 1; h3 = 1;
        movf = 0; hv = 0; hk = 0;
    endtask

    task automatic do_make(input int b, input int ext);
        int d;
`ifdef TYPEMATIC_FILTER_EN
        if (hv && hk == ext * 256 + b) return;
        hv = 1;
        hk = ext * 256 + b;
`endif
        mlast = b;
        if (ext == 0) begin
            d = digit(b);
            if (d >= 1 && d <= NC) begin
                mcur = d - 1; sched_v = 1; sched_c = d - 1;
            end else if (b == 'h5A || b == 'h29) begin
                sched_v = 1; sched_c = mcur;
            end
        end else begin
            if (b == 'h6B) mcur = (mcur + NC - 1) % NC;
            if (b == 'h74) mcur = (mcur + 1) % NC;
        end
    endtask

    task automatic do_break(input int b, input int ext);
`ifdef TYPEMATIC_FILTER_EN
        if (hv && hk == ext * 256 + b) hv = 0;
`else
        if (b < 0 || ext < 0) hv = 0;
`endif
    endtask

    task automatic model_step();
        bit ps2p, dp, pop, lost, fall;
        int pc, b;
        ps2p = sched_v;
        dp   = sched_v || pend;
        pc   = sched_v ? sched_c : mcur;
        pop  = (mq.size() > 0) && move_ready;
        lost = dp && mq.size() == DEP && !pop;
        if (pop) void'(mq.pop_front());
        if (dp && !lost) mq.push_back(pc);
        movf = (movf && !ovf_clr) || lost;
        fall = h3 && !h2;
        pend = fall || (pend && ps2p);
        h3 = h2; h2 = h1; h1 = btn_drop_n;
        sched_v = 0;
        if (rx_en) begin
            b = int'(rx_data);
            case (mst)
                0: if (b == 'hE0) mst = 1;
                   else if (b == 'hF0) mst = 2;
                   else do_make(b, 0);
                1: if (b == 'hF0) mst = 3;
                   else begin do_make(b, 1); mst = 0; end
                2: begin do_break(b, 0); mst = 0; end
                default: begin do_break(b, 1); mst = 0; end
            endcase
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) model_reset();
        else model_step();
        #1;
        chk("m_valid", int'(move_valid), int'(mq.size() > 0));
        chk("m_col", int'(move_col), mq.size() > 0 ? mq[0] : 0);
        chk("m_count", int'(fifo_count), mq.size());
        chk("m_cursor", int'(cursor_col), mcur);
        chk("m_ovf", int'(overflow), int'(movf));
        chk("m_last", int'(last_code), mlast);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_en = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, int'(move_valid), 0);
        chk({nm, "_cursor"}, int'(cursor_col), 0);
        chk({nm, "_count"}, int'(fifo_count), 0);
        chk({nm, "_ovf"}, int'(overflow), 0);
        chk({nm, "_last"}, int'(last_code), 0);
        chk({nm, "_col"}, int'(move_col), 0);
    endtask

    logic [7:0] pool [16];

    initial begin
        resetn = 1'b0; rx_en = 1'b0; rx_data = 8'h00;
        btn_drop_n = 1'b1; move_ready = 1'b0; ovf_clr = 1'b0;
        #1;
        chk_zero("rst");
        tick(2);
        resetn = 1'b1;

        send(8'h16);
        chk("t1_early", int'(move_valid), 0);
        tick(1);
        chk("t1_valid", int'(move_valid), 1);
        chk("t1_col0", int'(move_col), 0);
        send(8'h3D);
        tick(1);
        chk("t1_cur6", int'(cursor_col), 6);
        chk("t1_cnt2", int'(fifo_count), 2);
        move_ready = 1'b1;
        tick(1);
        chk("t1_col6", int'(move_col), 6);
        tick(1);
        move_ready = 1'b0;
        chk("t1_drain", int'(fifo_count), 0);

        send(8'h16);
        tick(1);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        send(8'hE0); send(8'h6B);
        tick(1);
        chk("t2_left", int'(cursor_col), 6);
        send(8'hE0); send(8'h74);
        tick(1);
        chk("t2_right", int'(cursor_col), 0);
        chk("t2_nopush", int'(fifo_count), 0);

        send(8'h46);
        tick(2);
        chk("t3_d9", int'(fifo_count), 0);
        chk("t3_last", int'(last_code), 'h46);
        send(8'hF0); send(8'h16);
        tick(2);
        chk("t3_brk", int'(fifo_count), 0);
        send(8'hE0); send(8'hF0); send(8'h6B);
        tick(2);
        chk("t3_brkx", int'(cursor_col), 0);

        send(8'h16); send(8'h1E); send(8'h26);
        send(8'h25); send(8'h2E);
        tick(2);
        chk("t4_full", int'(fifo_count), 4);
        chk("t4_ovf", int'(overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t4_clr", int'(overflow), 0);
        move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", int'(move_col), i);
            tick(1);
        end
        move_ready = 1'b0;
        chk("t4_empty", int'(fifo_count), 0);

        send(8'h36);
        tick(1);
        move_ready = 1'b1;
        tick(1);
        move_ready = 1'b0;
        @(negedge clk);
        btn_drop_n = 1'b0;
        @(negedge clk);
        send(8'h26);
        tick(1);
        chk("t5_first", int'(fifo_count), 1);
        chk("t5_col", int'(move_col), 2);
        tick(1);
        chk("t5_btn", int'(fifo_count), 2);
        btn_drop_n = 1'b1;
        move_ready = 1'b1;
        tick(1);
        chk("t5_col2", int'(move_col), 2);
        tick(1);
        move_ready = 1'b0;

        send(8'hE0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_zero("t6_rst");
        @(negedge clk);
        resetn = 1'b1;
        send(8'h6B);
        tick(2);
        chk("t6_plain", int'(cursor_col), 0);
        chk("t6_last", int'(last_code), 'h6B);
        send(8'h16); send(8'h16); send(8'h16);
        tick(2);
`ifdef TYPEMATIC_FILTER_EN
        chk("t6_rep", int'(fifo_count), 1);
`else
        chk("t6_rep", int'(fifo_count), 3);
`endif
        send(8'hF0); send(8'h16); send(8'h16);
        tick(2);
`ifdef TYPEMATIC_FILTER_EN
        chk("t6_rel", int'(fifo_count), 2);
`else
        chk("t6_rel", int'(fifo_count), 4);
`endif

        pool = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                 8'h3D, 8'h3E, 8'h46, 8'h5A, 8'h29, 8'hE0,
                 8'hF0, 8'h6B, 8'h74, 8'h1C};
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 699) != 0);
            rx_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 16) == 16)
                rx_data = 8'($urandom);
            else
                rx_data = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) btn_drop_n = ~btn_drop_n;
            move_ready = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        rx_en = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
